// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : muldiv_sequencer
// Description: Iterative unsigned multiply / restoring divide, one bit per
//              cycle, stalling the execute stage until the result is ready.
//              Optional macro MULDIV_EARLY_OUT_EN ends MUL once the remaining
//              multiplier bits are all zero.
// Revision   : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isMul,
    input  logic             isDiv,
    input  logic             isMod,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mod_q, mod_d;
    // a: multiplicand (MUL) or dividend/quotient (DIV); b: multiplier or divisor
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // acc: running product (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               w_any_op;
    logic               w_mul_last;
    logic               w_ge;
    logic [WIDTH-1:0]   w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_rem_next;

    assign w_any_op  = isMul | isDiv | isMod;
    assign w_mul_sum = acc_q + (b_q[0] ? a_q : '0);
    assign w_rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, b_q});
    assign w_rem_sub = WIDTH'(w_rem_sh - {1'b0, b_q});
    assign w_quo_next = {a_q[WIDTH-2:0], w_ge};
    assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_last = (cnt_q == '0) || (b_q[WIDTH-1:1] == '0);
`else
    assign w_mul_last = (cnt_q == '0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mod_d    = mod_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start && w_any_op) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    acc_d = '0;
                    cnt_d = CNT_W'(WIDTH - 1);
                    mod_d = !isMul && !isDiv;
                    if (isMul) begin
                        state_d = S_MUL;
                    end else if (op_b == '0) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        dbz_d    = 1'b1;
                        result_d = isDiv ? {WIDTH{1'b1}} : op_a;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = w_mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (w_mul_last) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    dbz_d    = 1'b0;
                    result_d = w_mul_sum;
                end
            end
            S_DIV: begin
                acc_d = w_rem_next;
                a_d   = w_quo_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    dbz_d    = 1'b0;
                    result_d = mod_q ? w_rem_next : w_quo_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect abandons the operation without disturbing the last result
        if (flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            dbz_d    = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mod_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mod_q    <= mod_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign stall       = ((state_q == S_IDLE) && start && w_any_op)
                       || (state_q == S_MUL) || (state_q == S_DIV);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_muldiv_sequencer
// Description: Directed and randomized checks of muldiv_sequencer against an
//              arithmetic reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             isMul = 1'b0;
    logic             isDiv = 1'b0;
    logic             isMod = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             flush = 1'b0;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] last_result = '0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .isMul(isMul), .isDiv(isDiv),
        .isMod(isMod), .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mul_latency(input logic [WIDTH-1:0] b);
        int msb1 = 0;
`ifdef MULDIV_EARLY_OUT_EN
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb1 = i + 1;
        return 1 + ((msb1 < 1) ? 1 : msb1);
`else
        msb1 = b[0];
        return WIDTH + 1 + (msb1 - msb1);
`endif
    endfunction

    task automatic drive_req(input logic m, input logic d, input logic md,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1; isMul = m; isDiv = d; isMod = md; op_a = a; op_b = b;
    endtask

    task automatic clear_req();
        start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
    endtask

    // Issues one request at a negedge and follows it to its done pulse
    task automatic do_op(input logic m, input logic d, input logic md,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit poke_done, input string tag);
        logic [WIDTH-1:0] exp_res;
        logic             exp_dbz;
        int               exp_lat;
        int               cyc;
        longint unsigned  prod;

        exp_dbz = 1'b0;
        if (m) begin
            prod    = longint'(a) * longint'(b);
            exp_res = prod[WIDTH-1:0];
            exp_lat = mul_latency(b);
        end else if (b == 0) begin
            exp_res = d ? {WIDTH{1'b1}} : a;
            exp_dbz = 1'b1;
            exp_lat = 1;
        end else begin
            exp_res = d ? (a / b) : (a % b);
            exp_lat = WIDTH + 1;
        end

        @(negedge clk);
        drive_req(m, d, md, a, b);
        #1 chk({tag, ".stall0"}, 32'(stall), 32'd1);
        @(negedge clk);
        clear_req();
        cyc = 1;
        while (done !== 1'b1 && cyc < 3 * WIDTH) begin
            chk({tag, ".stall_busy"}, 32'(stall), 32'd1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".result"}, 32'(result), 32'(exp_res));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        if (poke_done) drive_req(1'b1, 1'b0, 1'b0, a, b);
        @(negedge clk);
        clear_req();
        #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, 32'(result), 32'(exp_res));
        chk({tag, ".idle_stall"}, 32'(stall), 32'd0);
        if (poke_done) begin
            for (int k = 0; k < WIDTH + 3; k++) begin
                @(negedge clk);
                chk({tag, ".poke_nodone"}, 32'(done), 32'd0);
            end
        end
        last_result = exp_res;
    endtask

    // Starts a 1000/7 divide, then aborts it in cycle 8 with flush or rst
    task automatic abort_op(input bit use_rst, input string tag);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 16'd1000, 16'd7);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            clear_req();
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".result"}, 32'(result), use_rst ? 32'd0 : 32'(last_result));
        if (use_rst) chk({tag, ".dbz"}, 32'(div_by_zero), 32'd0);
        for (int k = 0; k < WIDTH + 3; k++) begin
            @(negedge clk);
            chk({tag, ".nodone"}, 32'(done), 32'd0);
        end
        if (use_rst) last_result = '0;
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]       fl;
        logic [WIDTH-1:0] ra, rb;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.dbz", 32'(div_by_zero), 32'd0);

        do_op(1'b1, 1'b0, 1'b0, 16'd300, 16'd7, 1'b0, "mul300x7");
        do_op(1'b0, 1'b1, 1'b0, 16'd1000, 16'd7, 1'b0, "div1000_7");
        do_op(1'b0, 1'b0, 1'b1, 16'd1000, 16'd7, 1'b0, "mod1000_7");
        do_op(1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 1'b0, "div5_0");
        do_op(1'b0, 1'b0, 1'b1, 16'd5, 16'd0, 1'b0, "mod5_0");
        do_op(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, "mulFFFF");
        do_op(1'b1, 1'b1, 1'b0, 16'd1000, 16'd7, 1'b0, "mul_div_flags");
        do_op(1'b0, 1'b1, 1'b1, 16'd1000, 16'd7, 1'b0, "div_mod_flags");
        do_op(1'b1, 1'b0, 1'b0, 16'd1234, 16'd0, 1'b0, "mul_by0");
        do_op(1'b0, 1'b1, 1'b0, 16'd77, 16'd1, 1'b1, "start_in_done");

        // start without an op flag is ignored
        @(negedge clk);
        start = 1'b1; op_b = 16'd3;
        #1 chk("noflag.stall", 32'(stall), 32'd0);
        @(negedge clk);
        clear_req();
        #1;
        chk("noflag.stall_next", 32'(stall), 32'd0);
        chk("noflag.done", 32'(done), 32'd0);

        abort_op(1'b0, "flush");
        abort_op(1'b1, "rst");

        for (int n = 0; n < 40; n++) begin
            fl = 3'($urandom_range(1, 7));
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = WIDTH'($urandom_range(1, 15));
                default: rb = WIDTH'($urandom);
            endcase
            do_op(fl[2], fl[1], fl[0], ra, rb, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
